ucounter8_seq: RTL

//  Command sequencer for one ucounter8. Accepts count-run commands (start, target, direction, wrap/stop mode)

---
 rtl/ucounter8_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ucounter8_seq.sv
// Command sequencer for one ucounter8: queues count-run commands, loads each into the
// counter in turn and watches dcount/overflow until the target, a stuck terminal count or a timeout.
module ucounter8_seq #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 511
) (
  input  logic                         clk,
  input  logic                         _areset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [WIDTH-1:0]             cmd_start,
  input  logic [WIDTH-1:0]             cmd_target,
  input  logic                         cmd_up,
  input  logic                         cmd_stop,
  input  logic                         abort,
  input  logic [WIDTH-1:0]             dcount,
  input  logic                         overflow,
  output logic                         _load,
  output logic [WIDTH-1:0]             preld_val,
  output logic                         _updown,
  output logic                         _wrapstop,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         ovf_seen,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int LW  = $clog2(DEPTH+1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WDW = $clog2(TIMEOUT+1);
  localparam logic [LW-1:0]  FULL_LV = LW'(DEPTH);
  localparam logic [WDW-1:0] TO_V    = WDW'(TIMEOUT);

  typedef struct packed {
    logic [WIDTH-1:0] st;
    logic [WIDTH-1:0] tg;
    logic             up;
    logic             stop;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DONE, S_ERR} state_t;

  state_t           r_state, w_state_nxt;
  cmd_t             r_mem [DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_st, r_tg;
  logic             r_up, r_stop, r_ovf;
  logic [WDW-1:0]   r_wd;
  logic             w_push, w_pop, w_term;

  // Abort blocks both sides of the FIFO for that cycle; the flush wins.
  assign cmd_ready = (r_level != FULL_LV);
  assign w_push    = cmd_valid & cmd_ready & ~abort;
  assign w_pop     = (r_state == S_IDLE) & (r_level != '0) & ~abort;
  assign w_term    = r_up ? (dcount == '1) : (dcount == '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= '{st: cmd_start, tg: cmd_target, up: cmd_up, stop: cmd_stop};
  end

  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else if (abort) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  // Working copy of the command; also drives the counter's mode pins.
  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      r_st   <= '0;
      r_tg   <= '0;
      r_up   <= 1'b1;
      r_stop <= 1'b0;
    end else if (w_pop) begin
      r_st   <= r_mem[r_rd].st;
      r_tg   <= r_mem[r_rd].tg;
      r_up   <= r_mem[r_rd].up;
      r_stop <= r_mem[r_rd].stop;
    end
  end

  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      r_ovf <= 1'b0;
      r_wd  <= '0;
    end else if (r_state == S_LOAD) begin
      r_ovf <= 1'b0;
      r_wd  <= '0;
    end else if (r_state == S_RUN) begin
      if (overflow) r_ovf <= 1'b1;
      r_wd <= r_wd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Priority inside RUN: abort, then target match, then stuck terminal, then watchdog.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_pop) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = abort ? S_ERR : S_RUN;
      S_RUN: begin
        if (abort)                 w_state_nxt = S_ERR;
        else if (dcount == r_tg)   w_state_nxt = S_DONE;
        else if (r_stop && w_term) w_state_nxt = S_ERR;
        else if (r_wd == TO_V)     w_state_nxt = S_ERR;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    _load      = ~((r_state == S_LOAD) & ~abort);
    preld_val  = r_st;
    _updown    = r_up;
    _wrapstop  = r_stop;
    busy       = (r_state == S_LOAD) | (r_state == S_RUN);
    done       = (r_state == S_DONE);
    err        = (r_state == S_ERR);
    ovf_seen   = r_ovf;
    fifo_level = r_level;
  end

endmodule
